// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder used as the per-bit datapath of serial_add_ctrl.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshakes: one operand bit per RUN cycle, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry_reg;
  logic             accept, last_bit, fa_sum, fa_cout;

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .Cin  (carry_reg),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Consuming the result and accepting new operands on one edge skips IDLE.
        if (out_ready) begin
          accept     = in_valid;
          state_next = in_valid ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg   <= '0;
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
    end else if (state_reg == RUN) begin
      cnt_reg   <= cnt_reg + 1'b1;
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      sum_reg   <= {fa_sum, sum_reg[WIDTH-1:1]};
      carry_reg <= fa_cout;
    end
  end

  // After the last RUN cycle the carry register holds the final carry-out.
  assign sum  = sum_reg;
  assign cout = carry_reg;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ovf_reg <= 1'b0;
    else if (state_reg == RUN && last_bit)  ovf_reg <= carry_reg ^ fa_cout;
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, handshake corner cases, random sweep.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + (c ? 1 : 0);
    return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
  endfunction

  // Output monitor: latency on each rise of out_valid, result check on each consumption.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
        else                check("latency", 32'(cyc - sb[0].acc_cyc), 32'(W));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
        $display("[TB] txn @%0d sum=0x%02h cout=%0d exp_sum=0x%02h exp_cout=%0d",
                 cyc, sum, cout, e.sum, e.cout);
      end
      prev_ov = out_valid;
    end
  end

  // Offers operands until accepted; returns the cycle number of the accepting edge.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                      input logic [W-1:0] es, input logic ec, input logic eo,
                      output int acc_cyc);
    int waited = 0;
    bit acc    = 1'b0;
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    acc_cyc  = cyc;
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back('{sum: es, cout: ec, ovf: eo, acc_cyc: cyc});
      check("busy_after_accept", 32'(busy), 32'd1);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[8];
    int           acc1, acc2, k, bad;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rs;

    vt[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
    vt[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, sum: 8'h01, cout: 1'b1, ovf: 1'b0};
    vt[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vt[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0, ovf: 1'b0};
    vt[4] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
    vt[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vt[6] = '{a: 8'h22, b: 8'h11, cin: 1'b0, sum: 8'h33, cout: 1'b0, ovf: 1'b0};
    vt[7] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Vector table, issued back to back
    for (int i = 0; i < 8; i++)
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sum, vt[i].cout, vt[i].ovf, acc1);
    drain();

    // Consume and accept on the same edge: no IDLE cycle in between
    send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, acc1);
    send(8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0, acc2);
    check("b2b_no_idle", 32'(acc2 - acc1), 32'(W + 1));
    drain();

    // Consumer stalls in DONE for 5 cycles while new operands are offered
    out_ready = 1'b0;
    send(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, model_ovf(8'h5A, 8'h3C, 1'b1), acc1);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("stall_reach_done", 32'(out_valid), 32'd1);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'h97);
      check("stall_cout", 32'(cout), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_to_idle_out_valid", 32'(out_valid), 32'd0);
    check("stall_to_idle_in_ready", 32'(in_ready), 32'd1);
    check("stall_to_idle_busy", 32'(busy), 32'd0);
    check("stall_drained", 32'(sb.size()), 32'd0);

    // Reset during RUN aborts the operation
    send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, acc1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("abort_no_out_valid", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, acc1);
    drain();

    // Random operand sweep against a reference sum
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = {1'b0, ra} + {1'b0, rb} + (W + 1)'(rc);
      send(ra, rb, rc, rs[W-1:0], rs[W], model_ovf(ra, rb, rc), acc1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
